// File: rtl/instruction_buffer.sv
// instruction_buffer: circular fetch-to-decode queue, up to two pushes and one pop per cycle
module instruction_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instructionA,
  input  logic [31:0]              instructionB,
  input  logic [31:0]              addressA,
  input  logic [31:0]              addressB,
  input  logic                     instructionA_valid,
  input  logic                     instructionB_valid,
  input  logic                     flush,
  output logic                     stall,
  output logic                     issue_valid,
  output logic [31:0]              issue_instruction,
  output logic [31:0]              issue_address,
  input  logic                     issue_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_addr  [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr1;
  logic [CW-1:0] w_npush;
  logic          w_push_a, w_push_b, w_pop;

  // Stall looks only at registered occupancy so the fetcher never sees a combinational loop;
  // two free slots are reserved so a double push can never overflow.
  assign stall             = r_count > CW'(DEPTH - 2);
  assign issue_valid       = r_count != '0;
  assign issue_instruction = r_instr[r_rd];
  assign issue_address     = r_addr[r_rd];
  assign count             = r_count;
  assign w_push_a          = !stall && instructionA_valid && !flush;
  assign w_push_b          = w_push_a && instructionB_valid;
  assign w_pop             = issue_valid && issue_ready && !flush;
  assign w_npush           = CW'(w_push_a) + CW'(w_push_b);
  assign w_wr1             = r_wr + AW'(1);

  // Storage is never reset; entries are only observable once counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push_a) begin
      r_instr[r_wr] <= instructionA;
      r_addr[r_wr]  <= addressA;
    end
    if (w_push_b) begin
      r_instr[w_wr1] <= instructionB;
      r_addr[w_wr1]  <= addressB;
    end
  end

  // Pointers wrap naturally at AW bits; flush discards everything including same-cycle traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= r_rd + AW'(w_pop);
      r_wr    <= r_wr + w_npush[AW-1:0];
      r_count <= r_count + w_npush - CW'(w_pop);
    end
  end
endmodule

// File: doc/instruction_buffer.md
INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instructionA  input  32  lower-address instruction from fetcher.
REQ-005 SHALL have port instructionB  input  32  upper-address instruction from fetcher.
REQ-006 SHALL have port addressA  input  32  PC of instructionA.
REQ-007 SHALL have port addressB  input  32  PC of instructionB.
REQ-008 SHALL have port instructionA_valid  input  1  instructionA offered this cycle.
REQ-009 SHALL have port instructionB_valid  input  1  instructionB offered this cycle; meaningful only with instructionA_valid.
REQ-010 SHALL have port flush  input  1  branch redirect; discard all buffered and offered entries.
REQ-011 SHALL have port stall  output  1  back-pressure to fetcher; buffer accepts nothing while high.
REQ-012 SHALL have port issue_valid  output  1  head entry available to decode.
REQ-013 SHALL have port issue_instruction  output  32  head entry instruction.
REQ-014 SHALL have port issue_address  output  32  head entry PC.
REQ-015 SHALL have port issue_ready  input  1  decode accepts head entry this cycle.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL store {instruction, address} pairs in a circular array with registered read pointer, write pointer and occupancy count.
REQ-018 SHALL drive stall combinationally from registered state only: stall = (count > DEPTH-2), i.e. high when fewer than 2 slots free.
REQ-019 SHALL push nothing when stall is high, regardless of valid inputs.
REQ-020 SHALL, when stall low and instructionA_valid high, write A at write pointer; if instructionB_valid also high, write B at write pointer+1 (double push).
REQ-021 SHALL ignore instructionB_valid when instructionA_valid is low (no push of B alone).
REQ-022 SHALL drive issue_valid = (count != 0) and issue_instruction/issue_address from the head entry combinationally, zero latency from storage.
REQ-023 SHALL pop one entry per cycle when issue_valid and issue_ready are both high.
REQ-024 SHALL advance pointers modulo DEPTH; wrap-around invisible at outputs.
REQ-025 SHALL update count by pushes minus pops in the same cycle (range -1..+2); simultaneous push and pop SHALL both take effect.
REQ-026 SHALL, on flush high at a clock edge, set count, read and write pointers to 0 and discard any same-cycle push and pop.
REQ-027 SHALL allow a push into an empty buffer to appear at issue_valid one cycle after the push edge (no bypass).
REQ-028 SHALL never overflow: guaranteed by REQ-018; pop with count 0 SHALL be impossible since issue_valid is low.
REQ-029 SHALL keep issue_instruction/issue_address stable while issue_valid high and issue_ready low.
REQ-030 SHALL not depend on stall from downstream; stall is an output only.

Reset
REQ-031 SHALL, while reset low, asynchronously force count=0, pointers=0, hence issue_valid=0 and stall=0.
REQ-032 SHALL not require storage array contents to be reset; issue_instruction/issue_address are don't-care while issue_valid is low.
REQ-033 SHALL accept pushes on the first rising edge after reset deasserts; reset asserted mid-operation SHALL discard all entries immediately.

Verification
REQ-034 SHALL cover double push: A=00000000@0x0, B=11111111@0x4, both valid, issue_ready=0 -> next cycle count=2, issue_valid=1, issue_instruction=00000000, issue_address=0x0.
REQ-035 SHALL cover fill to stall with DEPTH=8, issue_ready=0: four double pushes -> count=8, stall=1; then offered A/B with valid high -> count stays 8; one pop -> count=7, stall stays 1; second pop -> count=6, stall=0.
REQ-036 SHALL cover single push: A=22222222 valid, B valid low -> count +1; B valid high with A valid low -> count unchanged.
REQ-037 SHALL cover simultaneous push-pop: count=3, double push plus pop -> count=4, issue order preserved (FIFO order A before B, by address).
REQ-038 SHALL cover flush: count=5 with push and pop asserted same edge as flush -> count=0, issue_valid=0 next cycle; next push of A=CCCCCCCC@0x30 issues first.
REQ-039 SHALL cover wrap-around and reset: 20 alternating double pushes/pops drain in exact push order across pointer wrap; reset pulled low mid-stream -> count=0, issue_valid=0 without a clock edge.
